// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter slice: FSM encodings and default byte width.
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotating-priority search: the first requester after ptr (mod NUM_SRC) wins.
module rr_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] winner,
  output logic [IDX_W-1:0]   winIdx,
  output logic               anyReq
);

  int               cand;
  logic [IDX_W-1:0] candIdx;

  always_comb begin
    winner  = '0;
    winIdx  = '0;
    anyReq  = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand    = (int'(ptr) + i) % NUM_SRC;
      candIdx = IDX_W'(cand);
      if (!anyReq && req[candIdx]) begin
        anyReq          = 1'b1;
        winner[candIdx] = 1'b1;
        winIdx          = candIdx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the UART TX FIFO push port; a grant is held for a whole message.
//   state   | meaning
//   ST_IDLE | no grant; pick next requester after ptr
//   ST_XFER | granted source streams bytes until last, truncation or cancel
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = UART_DATA_W,
  parameter int MAX_LEN = 16
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [NUM_SRC-1:0]        iReq,
  input  logic [NUM_SRC-1:0]        iValid,
  input  logic [NUM_SRC*DATA_W-1:0] iData,
  input  logic [NUM_SRC-1:0]        iLast,
  input  logic                      iFull,
  output logic [NUM_SRC-1:0]        oGrant,
  output logic [NUM_SRC-1:0]        oAck,
  output logic                      oPush,
  output logic [DATA_W-1:0]         oWrData,
  output logic                      oBusy,
  output logic                      oAbort
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_t             state, stateNxt;
  logic [NUM_SRC-1:0] grant, grantNxt;
  logic [IDX_W-1:0]   gIdx, gIdxNxt;
  logic [IDX_W-1:0]   ptr, ptrNxt;
  logic [CNT_W-1:0]   count, countNxt;
  logic               abort, abortNxt;

  logic [NUM_SRC-1:0] winner;
  logic [IDX_W-1:0]   winIdx;
  logic               anyReq;
  logic               accept;
  logic [DATA_W-1:0]  srcData [NUM_SRC];

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign srcData[k] = iData[k*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) uRr (
    .req    (iReq),
    .ptr    (ptr),
    .winner (winner),
    .winIdx (winIdx),
    .anyReq (anyReq)
  );

  assign accept  = (state == ST_XFER) & iReq[gIdx] & iValid[gIdx] & ~iFull;
  assign oPush   = accept;
  assign oAck    = accept ? grant : '0;
  assign oWrData = accept ? srcData[gIdx] : '0;
  assign oGrant  = grant;
  assign oBusy   = (state == ST_XFER);
  assign oAbort  = abort;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= ST_IDLE;
      grant <= '0;
      gIdx  <= '0;
      ptr   <= IDX_W'(NUM_SRC - 1);
      count <= '0;
      abort <= 1'b0;
    end else begin
      state <= stateNxt;
      grant <= grantNxt;
      gIdx  <= gIdxNxt;
      ptr   <= ptrNxt;
      count <= countNxt;
      abort <= abortNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    grantNxt = grant;
    gIdxNxt  = gIdx;
    ptrNxt   = ptr;
    countNxt = count;
    abortNxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (anyReq) begin
          stateNxt = ST_XFER;
          grantNxt = winner;
          gIdxNxt  = winIdx;
          ptrNxt   = winIdx;
          countNxt = '0;
        end
      end
      ST_XFER: begin
        if (!iReq[gIdx]) begin
          stateNxt = ST_IDLE;
          grantNxt = '0;
          abortNxt = 1'b1;
        end else if (accept) begin
          if (iLast[gIdx]) begin
            stateNxt = ST_IDLE;
            grantNxt = '0;
          end else if (count == CNT_W'(MAX_LEN - 1)) begin
            // Message overran MAX_LEN: drop the grant so other sources are not starved.
            stateNxt = ST_IDLE;
            grantNxt = '0;
            abortNxt = 1'b1;
          end else begin
            countNxt = count + 1'b1;
          end
        end
      end
      default: begin
        stateNxt = ST_IDLE;
        grantNxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_SRC=3, DATA_W=8, MAX_LEN=16).
module tb_uart_tx_arbiter;

  localparam int NUM_SRC = 3;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 16;

  logic                      iClk = 1'b0;
  logic                      iRst;
  logic [NUM_SRC-1:0]        iReq;
  logic [NUM_SRC-1:0]        iValid;
  logic [NUM_SRC*DATA_W-1:0] iData;
  logic [NUM_SRC-1:0]        iLast;
  logic                      iFull;
  logic [NUM_SRC-1:0]        oGrant;
  logic [NUM_SRC-1:0]        oAck;
  logic                      oPush;
  logic [DATA_W-1:0]         oWrData;
  logic                      oBusy;
  logic                      oAbort;

  int checks = 0;
  int errors = 0;
  logic [7:0] pushLog[$];

  uart_tx_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iReq    (iReq),
    .iValid  (iValid),
    .iData   (iData),
    .iLast   (iLast),
    .iFull   (iFull),
    .oGrant  (oGrant),
    .oAck    (oAck),
    .oPush   (oPush),
    .oWrData (oWrData),
    .oBusy   (oBusy),
    .oAbort  (oAbort)
  );

  always #5 iClk = ~iClk;

  // FIFO-side capture of every pushed byte
  always @(negedge iClk) if (oPush) pushLog.push_back(oWrData);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic doReset();
    iRst   = 1'b1;
    iReq   = '0;
    iValid = '0;
    iData  = '0;
    iLast  = '0;
    iFull  = 1'b0;
    step();
    step();
    iRst = 1'b0;
    pushLog.delete();
  endtask

  task automatic xferByte(input int s, input logic [7:0] d, input logic last);
    logic [2:0] oh;
    oh = 3'b001 << s;
    iValid[s]        = 1'b1;
    iData[s*8 +: 8]  = d;
    iLast[s]         = last;
    #1;
    chk("grant", 32'(oGrant), 32'(oh));
    chk("push", 32'(oPush), 32'd1);
    chk("wrData", 32'(oWrData), 32'(d));
    chk("ack", 32'(oAck), 32'(oh));
    chk("abortIdle", 32'(oAbort), 32'd0);
    step();
    iLast[s] = 1'b0;
  endtask

  task automatic chkLog(input string tag, input logic [7:0] exp[$]);
    chk({tag, "Size"}, 32'(pushLog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < pushLog.size(); i++)
      chk({tag, "Byte"}, 32'(pushLog[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp[$];
    int s;

    // reset state
    iRst = 1'b1; iReq = '0; iValid = '0; iData = '0; iLast = '0; iFull = 1'b0;
    #2;
    chk("rstGrant", 32'(oGrant), 32'd0);
    chk("rstBusy", 32'(oBusy), 32'd0);
    chk("rstAbort", 32'(oAbort), 32'd0);
    chk("rstPush", 32'(oPush), 32'd0);
    chk("rstWrData", 32'(oWrData), 32'd0);
    doReset();

    // 1: single 3-byte message from src0
    iReq = 3'b001;
    iValid[0] = 1'b1; iData[7:0] = 8'h41;
    #1;
    chk("t1PreGrant", 32'(oGrant), 32'd0);
    chk("t1PrePush", 32'(oPush), 32'd0);
    step();
    chk("t1Busy", 32'(oBusy), 32'd1);
    xferByte(0, 8'h41, 1'b0);
    xferByte(0, 8'h42, 1'b0);
    xferByte(0, 8'h43, 1'b1);
    iReq = '0; iValid = '0;
    #1;
    chk("t1Release", 32'(oGrant), 32'd0);
    chk("t1Busy0", 32'(oBusy), 32'd0);
    chk("t1Abort", 32'(oAbort), 32'd0);
    exp = '{8'h41, 8'h42, 8'h43};
    chkLog("t1Log", exp);

    // 2: three sources always requesting -> 0,1,2,0,1,2
    doReset();
    iReq = 3'b111; iValid = 3'b111; iData = 24'hCC_BB_AA;
    step();
    exp.delete();
    for (int m = 0; m < 6; m++) begin
      s = m % 3;
      xferByte(s, 8'(8'h10 * (m + 1)), 1'b0);
      xferByte(s, 8'(8'h10 * (m + 1) + 1), 1'b1);
      exp.push_back(8'(8'h10 * (m + 1)));
      exp.push_back(8'(8'h10 * (m + 1) + 1));
      chk("t2Dead", 32'(oGrant), 32'd0);
      chk("t2DeadPush", 32'(oPush), 32'd0);
      chk("t2Abort", 32'(oAbort), 32'd0);
      step();
    end
    chkLog("t2Log", exp);

    // 3: FIFO full stalls a 4-byte message from src1
    doReset();
    iReq = 3'b010;
    step();
    xferByte(1, 8'hA0, 1'b0);
    xferByte(1, 8'hA1, 1'b0);
    iFull = 1'b1; iValid[1] = 1'b1; iData[15:8] = 8'hA2;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t3FullPush", 32'(oPush), 32'd0);
      chk("t3FullAck", 32'(oAck), 32'd0);
      chk("t3FullGrant", 32'(oGrant), 32'b010);
      step();
    end
    iFull = 1'b0;
    xferByte(1, 8'hA2, 1'b0);
    xferByte(1, 8'hA3, 1'b1);
    iReq = '0; iValid = '0;
    step();
    exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    chkLog("t3Log", exp);

    // 4: src2 overruns MAX_LEN while src0 waits
    doReset();
    iReq = 3'b100;
    step();
    iReq[0] = 1'b1;
    exp.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      xferByte(2, 8'(8'h60 + i), 1'b0);
      exp.push_back(8'(8'h60 + i));
    end
    iData[23:16] = 8'h70;
    #1;
    chk("t4Abort", 32'(oAbort), 32'd1);
    chk("t4Grant", 32'(oGrant), 32'd0);
    chk("t4Push", 32'(oPush), 32'd0);
    iReq[2] = 1'b0; iValid[2] = 1'b0;
    step();
    chk("t4AbortPulse", 32'(oAbort), 32'd0);
    chk("t4NextGrant", 32'(oGrant), 32'b001);
    chkLog("t4Log", exp);

    // 5: src0 cancels mid-message
    doReset();
    iReq = 3'b001;
    step();
    xferByte(0, 8'h51, 1'b0);
    xferByte(0, 8'h52, 1'b0);
    iReq = '0; iValid = '0;
    #1;
    chk("t5NoPush", 32'(oPush), 32'd0);
    step();
    chk("t5Abort", 32'(oAbort), 32'd1);
    chk("t5Grant", 32'(oGrant), 32'd0);
    step();
    chk("t5AbortPulse", 32'(oAbort), 32'd0);
    chk("t5Push", 32'(oPush), 32'd0);
    exp = '{8'h51, 8'h52};
    chkLog("t5Log", exp);

    // 6: async reset during src1 transfer
    doReset();
    iReq = 3'b010;
    step();
    xferByte(1, 8'h81, 1'b0);
    iValid[1] = 1'b1; iData[15:8] = 8'h82;
    #1;
    chk("t6PushPre", 32'(oPush), 32'd1);
    iRst = 1'b1;
    #1;
    chk("t6RstGrant", 32'(oGrant), 32'd0);
    chk("t6RstPush", 32'(oPush), 32'd0);
    chk("t6RstBusy", 32'(oBusy), 32'd0);
    step();
    iRst = 1'b0; iReq = 3'b111;
    step();
    chk("t6FirstGrant", 32'(oGrant), 32'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
